// File: rtl/sha256_arbiter_pkg.sv
// Shared definitions for the SHA-256 core arbiter: block width, FSM encoding
// and the pointer-width helper used to size round-robin indices.
package sha256_arbiter_pkg;

    localparam int BLOCK_W = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha256_arbiter_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after the
// pointer, wrapping modulo NUM_REQ.
module sha256_arbiter_rr_pick
    import sha256_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [PTR_W-1:0] w_j;

    // Scan from the pointer and latch the first pending requester found.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_j      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_pending[w_j]) begin
                o_valid       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = w_j;
            end else begin
            end
        end
    end

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one SHA-256 core between NUM_REQ requesters with round-robin
// arbitration and an optional lock that keeps the core across hashes.
module sha256_arbiter
    import sha256_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int KEY_LEN = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_start,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]         req_message_length,
    input  logic [NUM_REQ-1:0]         req_continue_intermediate,
    input  logic [NUM_REQ-1:0]         req_store_intermediate,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [KEY_LEN-1:0]         req_data_out,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       hash_start,
    output logic [BLOCK_W-1:0]         hash_data_in,
    output logic                       message_length,
    output logic                       continue_intermediate,
    output logic                       store_intermediate,
    input  logic                       hash_done,
    input  logic [KEY_LEN-1:0]         hash_data_out,
    output logic                       busy
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_pending, w_pending_nxt, w_pending_clr;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [PTR_W-1:0]   r_gidx, w_gidx_nxt;
    logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_valid;

    sha256_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_onehot  (w_pick_onehot),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    // Next-state, grant, pointer and pending-clear decisions.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_pending_clr = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt   = ST_ISSUE;
                    w_grant_nxt   = w_pick_onehot;
                    w_gidx_nxt    = w_pick_idx;
                    w_pending_clr = w_pick_onehot;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (hash_done) begin
                    w_rr_ptr_nxt = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
                    if (req_lock[r_gidx]) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // Only the locked owner may reissue; everyone else keeps waiting.
                if (r_pending[r_gidx]) begin
                    w_state_nxt   = ST_ISSUE;
                    w_pending_clr = r_grant;
                end else if (!req_lock[r_gidx]) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
        // A start from the requester being issued is absorbed by the clear.
        w_pending_nxt = (r_pending | req_start) & ~w_pending_clr;
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
        end
    end

    // Core-facing mux driven from the current owner, zero when no owner.
    always_comb begin
        hash_data_in          = '0;
        message_length        = 1'b0;
        continue_intermediate = 1'b0;
        store_intermediate    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                hash_data_in          = hash_data_in | req_data_in[i*BLOCK_W +: BLOCK_W];
                message_length        = message_length | req_message_length[i];
                continue_intermediate = continue_intermediate | req_continue_intermediate[i];
                store_intermediate    = store_intermediate | req_store_intermediate[i];
            end else begin
            end
        end
    end

    // Status and completion outputs.
    always_comb begin
        hash_start   = (r_state == ST_ISSUE);
        req_done     = (r_state == ST_WAIT && hash_done) ? r_grant : '0;
        busy         = (r_state != ST_IDLE) || (|r_pending);
        grant        = r_grant;
        req_data_out = hash_data_out;
    end

endmodule

// File: tb/tb_sha256_arbiter.sv
// Scoreboard bench for sha256_arbiter with a behavioural SHA core stand-in.
module tb_sha256_arbiter;

    localparam int N  = 3;
    localparam int KL = 256;
    localparam int BW = 1024;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_start, req_lock, req_ml, req_ci, req_si;
    logic [N*BW-1:0] req_data_in;
    logic [N-1:0]    req_done, grant;
    logic [KL-1:0]   req_data_out, hash_data_out;
    logic            hash_start, hash_done;
    logic            message_length, continue_intermediate, store_intermediate;
    logic [BW-1:0]   hash_data_in;
    logic            busy;

    always #5 clk = ~clk;

    sha256_arbiter #(.NUM_REQ(N), .KEY_LEN(KL)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .req_start                 (req_start),
        .req_lock                  (req_lock),
        .req_data_in               (req_data_in),
        .req_message_length        (req_ml),
        .req_continue_intermediate (req_ci),
        .req_store_intermediate    (req_si),
        .req_done                  (req_done),
        .req_data_out              (req_data_out),
        .grant                     (grant),
        .hash_start                (hash_start),
        .hash_data_in              (hash_data_in),
        .message_length            (message_length),
        .continue_intermediate     (continue_intermediate),
        .store_intermediate        (store_intermediate),
        .hash_done                 (hash_done),
        .hash_data_out             (hash_data_out),
        .busy                      (busy)
    );

    typedef struct {
        int            idx;
        logic [KL-1:0] dig;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] r_blk [N];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            done_cnt = 0;
    int            m_ptr    = 0;
    int            core_lat = 64;
    int            core_cnt;
    logic          stray_req = 1'b0;

    function automatic logic [KL-1:0] fold(input logic [BW-1:0] d, input logic [2:0] c);
        return d[255:0] ^ d[511:256] ^ d[767:512] ^ d[1023:768] ^ {253'd0, c};
    endfunction

    task automatic chk(input string name, input logic [KL-1:0] got, input logic [KL-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Stand-in core: digest is a fold of the block and controls it was started with.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_cnt      <= 0;
            hash_done     <= 1'b0;
            hash_data_out <= '0;
        end else begin
            hash_done <= (core_cnt == 1) || stray_req;
            if (hash_start) begin
                core_cnt      <= core_lat;
                hash_data_out <= fold(hash_data_in, {message_length, continue_intermediate, store_intermediate});
            end else if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Monitor: every completion pulse must match the head of the scoreboard.
    initial begin
        exp_t         e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && req_done !== '0) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", KL'(req_done), '0);
                end else begin
                    e  = sb.pop_front();
                    oh = '0;
                    oh[2'(e.idx)] = 1'b1;
                    chk("done_owner", KL'(req_done), KL'(oh));
                    chk("digest", req_data_out, e.dig);
                end
            end
        end
    end

    task automatic randomize_reqs();
        for (int i = 0; i < N; i++) begin
            for (int w = 0; w < BW / 32; w++) r_blk[i][w*32 +: 32] = $urandom;
            req_data_in[i*BW +: BW] = r_blk[i];
            req_ml[2'(i)] = 1'($urandom_range(0, 1));
            req_ci[2'(i)] = 1'($urandom_range(0, 1));
            req_si[2'(i)] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic push_one(input int idx);
        exp_t e;
        e.idx = idx;
        e.dig = fold(r_blk[2'(idx)], {req_ml[2'(idx)], req_ci[2'(idx)], req_si[2'(idx)]});
        sb.push_back(e);
        m_ptr = (idx + 1) % N;
    endtask

    // Requests raised together from idle are served in rotation from the pointer.
    task automatic push_burst(input logic [N-1:0] mask);
        int start, j;
        start = m_ptr;
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (mask[2'(j)]) push_one(j);
        end
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        req_start = mask;
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((busy || sb.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(name, KL'(k >= 3000), '0);
        chk({name, "_grant"}, KL'(grant), '0);
    endtask

    task automatic wait_hs(input string name);
        int k = 0;
        while (!hash_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, KL'(k >= 100), '0);
    endtask

    initial begin
        int           base, k;
        logic         seen;
        logic [N-1:0] mask;
        reset = 1'b0; req_start = '0; req_lock = '0;
        req_ml = '0; req_ci = '0; req_si = '0; req_data_in = '0;
        for (int i = 0; i < N; i++) r_blk[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", KL'(grant), '0);
        chk("rst_busy", KL'(busy), '0);
        chk("rst_hash_start", KL'(hash_start), '0);
        chk("rst_req_done", KL'(req_done), '0);
        chk("rst_mux", KL'({|hash_data_in, message_length, continue_intermediate, store_intermediate}), '0);
        reset = 1'b1;
        @(negedge clk);

        // Contention: two full bursts from pointer 0.
        core_lat = 8;
        for (int b = 0; b < 2; b++) begin
            randomize_reqs();
            push_burst(3'b111);
            pulse(3'b111);
            wait_idle("contention");
        end

        // Single request with exact issue latency.
        core_lat = 64;
        randomize_reqs();
        push_burst(3'b010);
        req_start = 3'b010;
        @(negedge clk);
        req_start = '0;
        chk("latency_t1", KL'(hash_start), '0);
        @(negedge clk);
        chk("latency_t2", KL'(hash_start), KL'(1));
        chk("issue_data", KL'(hash_data_in === r_blk[1]), KL'(1));
        chk("grant_single", KL'(grant), KL'(3'b010));
        wait_idle("single");

        // Random bursts against the rotation model.
        for (int b = 0; b < 6; b++) begin
            core_lat = $urandom_range(2, 12);
            randomize_reqs();
            mask = 3'($urandom_range(1, 7));
            push_burst(mask);
            pulse(mask);
            wait_idle("random_burst");
        end

        // Lock: requester 2 keeps the core for two hashes while 0 waits.
        core_lat = 10;
        randomize_reqs();
        req_lock = 3'b100;
        push_one(2); push_one(2); push_one(0);
        base = done_cnt;
        pulse(3'b100);
        wait_hs("lock_first_issue");
        repeat (3) @(negedge clk);
        pulse(3'b101);
        k = 0;
        while (done_cnt < base + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("lock_two_dones", KL'(k >= 200), '0);
        req_lock = '0;
        seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (grant == 3'b001) seen = 1'b1;
        end
        chk("lock_release_grant", KL'(seen), KL'(1));
        wait_idle("lock");

        // Owner restarts in the same cycle as its own completion.
        core_lat = 6;
        randomize_reqs();
        push_one(0); push_one(0);
        base = done_cnt;
        pulse(3'b001);
        k = 0;
        while (hash_done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("same_cycle_reach", KL'(k >= 100), '0);
        pulse(3'b001);
        wait_idle("same_cycle");
        chk("same_cycle_dones", KL'(done_cnt - base), KL'(2));

        // Stray completion while idle.
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        chk("stray_req_done", KL'(req_done), '0);
        @(negedge clk);
        chk("stray_grant", KL'(grant), '0);
        chk("stray_busy", KL'(busy), '0);

        // Reset during a hash aborts it silently.
        core_lat = 30;
        randomize_reqs();
        pulse(3'b010);
        wait_hs("rst_mid_issue");
        repeat (4) @(negedge clk);
        base  = done_cnt;
        reset = 1'b0;
        #1;
        chk("rst_mid_grant", KL'(grant), '0);
        chk("rst_mid_done", KL'(req_done), '0);
        chk("rst_mid_busy", KL'(busy), '0);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", KL'(done_cnt - base), '0);
        core_lat = 5;
        randomize_reqs();
        push_burst(3'b100);
        pulse(3'b100);
        wait_idle("after_reset");

        chk("sb_empty", KL'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of requesters sharing one SHA-256 core (2..8).
REQ-002 SHALL have parameter KEY_LEN, default 256, meaning hash digest width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port req_start, input, NUM_REQ; per-requester one-cycle hash request pulse.
REQ-006 SHALL have port req_lock, input, NUM_REQ; while high, the granted requester keeps the core between hashes (multi-block / intermediate-state sequences).
REQ-007 SHALL have port req_data_in, input, NUM_REQ*1024; per-requester message block, requester i at bits [1024*i+1023:1024*i].
REQ-008 SHALL have ports req_message_length, req_continue_intermediate and req_store_intermediate, each input, NUM_REQ; per-requester core controls.
REQ-009 SHALL have port req_done, output, NUM_REQ; one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port req_data_out, output, KEY_LEN; hash_data_out broadcast unchanged to all requesters.
REQ-011 SHALL have port grant, output, NUM_REQ; one-hot current owner, all-zero when none.
REQ-012 SHALL have ports hash_start (output, 1), hash_data_in (output, 1024), message_length, continue_intermediate and store_intermediate (outputs, 1 each); these drive the core.
REQ-013 SHALL have ports hash_done (input, 1) and hash_data_out (input, KEY_LEN) from the core.
REQ-014 SHALL have port busy, output, 1; high when state is not IDLE or any pending bit is set.

Function
REQ-015 SHALL register a pending bit per requester, set on req_start[i], cleared in the cycle it enters ISSUE; set wins over clear for a different requester.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT and HOLD.
REQ-017 IDLE: if any pending, SHALL select the first pending index at or after rr_ptr (wrap modulo NUM_REQ), set grant and go to ISSUE; otherwise stay.
REQ-018 ISSUE: hash_start SHALL be 1 for exactly this cycle, then the block SHALL go to WAIT.
REQ-019 hash_data_in and the three core controls SHALL be combinationally muxed from the granted requester whenever grant is non-zero, and zero otherwise.
REQ-020 WAIT: on hash_done, req_done[g] SHALL equal 1 in the same cycle (combinational), and rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-021 On that hash_done, the next state SHALL be HOLD if req_lock[g]=1, otherwise IDLE with grant cleared.
REQ-022 HOLD: if pending[g], the block SHALL go to ISSUE with the same g; else if req_lock[g]=0, SHALL go to IDLE and clear grant; otherwise stay. Pending requests from other requesters SHALL wait.
REQ-023 Latency: req_start at cycle t in IDLE or HOLD SHALL give hash_start at cycle t+2.
REQ-024 req_done SHALL be 0 for non-owners; hash_done outside WAIT SHALL be ignored.
REQ-025 req_start from the owner during WAIT SHALL be latched and served after the current done: via HOLD if locked, otherwise through normal arbitration.
REQ-026 A repeated req_start while the requester's pending bit is already set SHALL be absorbed, with no second hash.
REQ-027 Requesters SHALL hold req_data_in and the control inputs stable from req_start until the ISSUE cycle; the arbiter stores no message data.

Reset
REQ-028 While reset=0, state SHALL be IDLE and pending, grant and rr_ptr SHALL be 0. hash_start, req_done and busy SHALL be 0, and the muxed outputs SHALL be 0.
REQ-029 Reset asserted mid-hash SHALL abort without any req_done pulse; the core is reset by the same signal.

Structure
REQ-030 State encoding, the CLOG2 macro use and the 1024-bit block width constant SHALL live in the shared hash package/include.
REQ-031 Round-robin selection SHALL be one sub-module, rr_pick (pending, rr_ptr -> one-hot, index, valid), and SHALL be purely combinational.

Verification
REQ-032 Single request: req_start[1] at t -> hash_start at t+2 with hash_data_in = req_data_in[1]; hash_done after 64 cycles -> req_done=3'b010 for one cycle; back to IDLE with grant=0.
REQ-033 Contention: req_start=3'b111 at t, rr_ptr=0 -> service order 0,1,2; next burst with rr_ptr=0 again -> 0,1,2; each req_done only to its owner.
REQ-034 Lock: req_lock[2]=1 and two successive starts from 2 while req_start[0] is pending -> both hashes from 2 complete before any from 0; dropping lock gives 0 the grant within 2 cycles.
REQ-035 Same-cycle event: req_start[0] in the same cycle as its own hash_done (unlocked) -> pending kept, hash reissued through arbitration, exactly two req_done pulses.
REQ-036 Reset mid-WAIT: reset=0 for 1 cycle -> grant=0, no req_done; a later request is served normally.
REQ-037 Stray hash_done in IDLE -> no req_done, no state change.
